// File: rtl/adc_serial_emulator_if.sv
// adc_serial_emulator_if: valid/ready sample port feeding the serial ADC emulator
interface adc_serial_emulator_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: CS_N/SCLK-driven ADC model shifting parallel samples out MSB-first on SDATA
module adc_serial_emulator #(
    parameter int   DATA_W      = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_BIT    = 1'b0
) (
    input  logic                    clk_100,
    input  logic                    RST,
    adc_serial_emulator_if.slave    s,
    input  logic                    CS_N,
    input  logic                    SCLK,
    output logic                    SDATA,
    output logic                    frame_done,
    output logic                    underrun
);
    localparam int          CW       = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST   = CW'(DATA_W - 1);
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SHIFT = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;

    logic [SYNC_STAGES:0] cs_q;
    logic [SYNC_STAGES:0] sclk_q;
    logic [1:0]           state;
    logic [DATA_W-1:0]    sh;
    logic [DATA_W-1:0]    hold;
    logic [DATA_W-1:0]    load_word;
    logic [CW-1:0]        cnt;
    logic                 full;
    logic                 cs_fall;
    logic                 cs_rise;
    logic                 sclk_fall;
    logic                 load;
    logic                 bypass;
    logic                 accept;

    // Synchronize CS_N and SCLK; the extra top flop holds the previous synchronized value for edge detection
    always_ff @(posedge clk_100) begin
        if (!RST) begin
            cs_q   <= '1;
            sclk_q <= '0;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-1:0], CS_N};
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], SCLK};
        end
    end

    assign cs_fall   = cs_q[SYNC_STAGES] & ~cs_q[SYNC_STAGES-1];
    assign cs_rise   = ~cs_q[SYNC_STAGES] & cs_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_q[SYNC_STAGES] & ~sclk_q[SYNC_STAGES-1];

    // A frame start with an empty holding register takes s_data directly when it is valid that cycle
    assign load      = (state == ST_IDLE) & cs_fall;
    assign bypass    = load & ~full & s.s_valid;
    assign s.s_ready = RST & ~full;
    assign accept    = s.s_valid & s.s_ready & ~bypass;
    assign load_word = full ? hold : (s.s_valid ? s.s_data : '0);

    // One-entry holding register: filled by the sample port, emptied when a frame loads it
    always_ff @(posedge clk_100) begin
        if (!RST) begin
            full <= 1'b0;
            hold <= '0;
        end else if (load && full) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
            hold <= s.s_data;
        end
    end

    // Frame FSM: load on CS_N fall, shift on SCLK fall, CS_N rise always returns to idle
    always_ff @(posedge clk_100) begin
        if (!RST) begin
            state      <= ST_IDLE;
            sh         <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state    <= ST_SHIFT;
                        sh       <= load_word;
                        cnt      <= '0;
                        underrun <= ~full & ~s.s_valid;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (sclk_fall) begin
                        if (cnt == LAST) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            sh  <= {sh[DATA_W-2:0], 1'b0};
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (cs_rise) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SDATA = (state == ST_SHIFT) ? sh[DATA_W-1] : IDLE_BIT;
endmodule
